// File: rtl/bank_wr_seq_pkg.sv
// Shared types and constants for the banked write sequencer.
// The bank index is 1-based on the wire; zero means no bank selected.
package bank_wr_seq_pkg;

    localparam int unsigned BANK_IDX_W = 4;
    localparam int unsigned MAX_BANK   = 15;
    localparam logic [BANK_IDX_W-1:0] BANK_NONE = 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bank_wr_seq_addr_ctr.sv
// Bank/address stripe counter: loads a burst origin and steps bank-first,
// bumping the in-bank address each time the rotation wraps to bank 1.
module bank_addr_ctr
    import bank_wr_seq_pkg::*;
#(
    parameter int unsigned NUM_BANK = 15,
    parameter int unsigned ADDR_W   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [BANK_IDX_W-1:0] base_bank,
    input  logic [ADDR_W-1:0]     base_addr,
    output logic [BANK_IDX_W-1:0] cur_bank,
    output logic [ADDR_W-1:0]     cur_addr
);

    localparam logic [BANK_IDX_W-1:0] FIRST_BANK = BANK_IDX_W'(1);
    localparam logic [BANK_IDX_W-1:0] LAST_BANK  = BANK_IDX_W'(NUM_BANK);

    logic [BANK_IDX_W-1:0] load_bank;

    // Out-of-range origins fall back to the first bank
    always_comb begin
        load_bank = base_bank;
        if (base_bank == BANK_NONE || base_bank > LAST_BANK) begin
            load_bank = FIRST_BANK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_bank <= FIRST_BANK;
            cur_addr <= '0;
        end else if (load) begin
            cur_bank <= load_bank;
            cur_addr <= base_addr;
        end else if (advance) begin
            if (cur_bank == LAST_BANK) begin
                cur_bank <= FIRST_BANK;
                cur_addr <= cur_addr + ADDR_W'(1);
            end else begin
                cur_bank <= cur_bank + BANK_IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/bank_wr_seq.sv
// Write sequencer: drains a valid/ready word stream into banked buffers,
// striping beats across banks with a registered one-beat write port.
module bank_wr_seq
    import bank_wr_seq_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_BANK = 15,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned LEN_W    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BANK_IDX_W-1:0] base_bank,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  wr_en,
    output logic [BANK_IDX_W-1:0] wr_bank,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data
);

    state_t                state;
    logic [LEN_W-1:0]      remaining;
    logic [BANK_IDX_W-1:0] cur_bank;
    logic [ADDR_W-1:0]     cur_addr;
    logic                  beat;
    logic                  load;

    assign busy     = (state == RUN);
    assign in_ready = (state == RUN);
    assign beat     = in_valid && (state == RUN);
    assign load     = start && (state == IDLE) && (len != '0);

    bank_addr_ctr #(
        .NUM_BANK (NUM_BANK),
        .ADDR_W   (ADDR_W)
    ) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .advance   (beat),
        .base_bank (base_bank),
        .base_addr (base_addr),
        .cur_bank  (cur_bank),
        .cur_addr  (cur_addr)
    );

    // FSM, beat counter and registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            done      <= 1'b0;
            wr_en     <= 1'b0;
            wr_bank   <= BANK_NONE;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            done    <= (state == DONE);
            wr_en   <= beat;
            wr_bank <= beat ? cur_bank : BANK_NONE;
            if (beat) begin
                wr_addr <= cur_addr;
                wr_data <= in_data;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= len;
                        state     <= (len != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bank_wr_seq.sv
// Randomized bench for bank_wr_seq: two instances (15 and 4 banks) share the
// stimulus and are checked against an arithmetic stripe model.
module tb_bank_wr_seq;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned LEN_W  = 10;
    localparam int NB_A = 15;
    localparam int NB_B = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        base_bank;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;

    logic              busy_a, done_a, in_ready_a, wr_en_a;
    logic [3:0]        wr_bank_a;
    logic [ADDR_W-1:0] wr_addr_a;
    logic [DATA_W-1:0] wr_data_a;
    logic              busy_b, done_b, in_ready_b, wr_en_b;
    logic [3:0]        wr_bank_b;
    logic [ADDR_W-1:0] wr_addr_b;
    logic [DATA_W-1:0] wr_data_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bank_wr_seq #(.DATA_W(DATA_W), .NUM_BANK(NB_A), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .base_bank(base_bank), .base_addr(base_addr),
        .len(len), .busy(busy_a), .done(done_a), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .wr_en(wr_en_a), .wr_bank(wr_bank_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a)
    );

    bank_wr_seq #(.DATA_W(DATA_W), .NUM_BANK(NB_B), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .base_bank(base_bank), .base_addr(base_addr),
        .len(len), .busy(busy_b), .done(done_b), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .wr_en(wr_en_b), .wr_bank(wr_bank_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Stripe model: beat i lands at linear slot (first-1)+i of a bank-major grid
    function automatic int exp_bank(input int nb, input int bb, input int i);
        int first;
        first = (bb == 0 || bb > nb) ? 1 : bb;
        return ((first - 1 + i) % nb) + 1;
    endfunction

    function automatic int exp_addr(input int nb, input int bb, input int ba, input int i);
        int first;
        first = (bb == 0 || bb > nb) ? 1 : bb;
        return (ba + (first - 1 + i) / nb) % (1 << ADDR_W);
    endfunction

    task automatic check_idle_port(input string tag);
        chk({tag, "_en_a"}, wr_en_a, 0);
        chk({tag, "_bank_a"}, wr_bank_a, 0);
        chk({tag, "_en_b"}, wr_en_b, 0);
        chk({tag, "_bank_b"}, wr_bank_b, 0);
    endtask

    task automatic check_write(input int bb, input int ba, input int i, input int data);
        chk("wr_en_a", wr_en_a, 1);
        chk("wr_bank_a", wr_bank_a, exp_bank(NB_A, bb, i));
        chk("wr_addr_a", wr_addr_a, exp_addr(NB_A, bb, ba, i));
        chk("wr_data_a", wr_data_a, data);
        chk("wr_en_b", wr_en_b, 1);
        chk("wr_bank_b", wr_bank_b, exp_bank(NB_B, bb, i));
        chk("wr_addr_b", wr_addr_b, exp_addr(NB_B, bb, ba, i));
        chk("wr_data_b", wr_data_b, data);
    endtask

    // vmode: 0 = valid held high, 1 = fixed 1,0,1,1,0,1 pattern, 2 = random
    task automatic run_burst(input int bb, input int ba, input int ln,
                             input int vmode, input bit extra_start);
        int  beat_n, cyc, prev_beat, prev_data;
        bit  prev_hs, v;
        logic [5:0] pat;
        pat = 6'b101101;
        @(negedge clk);
        start = 1'b1; base_bank = 4'(bb); base_addr = ADDR_W'(ba); len = LEN_W'(ln);
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        beat_n = 0; cyc = 0; prev_hs = 1'b0; prev_beat = 0; prev_data = 0;
        while (beat_n < ln && cyc < 400) begin
            if (prev_hs) check_write(bb, ba, prev_beat, prev_data);
            else check_idle_port("gap");
            chk("in_ready_a", in_ready_a, 1);
            chk("busy_b", busy_b, 1);
            chk("done_run", done_a, 0);
            case (vmode)
                0:       v = 1'b1;
                1:       v = pat[5 - (cyc % 6)];
                default: v = 1'($urandom % 2);
            endcase
            in_valid = v;
            in_data  = DATA_W'($urandom);
            start    = extra_start && (($urandom % 3) == 0);
            base_bank = 4'($urandom % 16); len = LEN_W'($urandom % 8);
            prev_hs = v; prev_beat = beat_n; prev_data = int'(in_data);
            if (v) beat_n++;
            @(negedge clk);
            cyc++;
        end
        if (beat_n < ln) chk("timeout_beats", beat_n, ln);
        start = 1'b0;
        in_valid = 1'($urandom % 2);
        if (ln > 0) check_write(bb, ba, ln - 1, prev_data);
        else check_idle_port("len0");
        chk("in_ready_end", in_ready_a, 0);
        chk("done_early_a", done_a, 0);
        chk("done_early_b", done_b, 0);
        @(negedge clk);
        chk("done_a", done_a, 1);
        chk("done_b", done_b, 1);
        chk("busy_done", busy_a, 0);
        check_idle_port("done_cyc");
        @(negedge clk);
        in_valid = 1'b0;
        chk("done_pulse", done_a, 0);
        check_idle_port("post");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_bank = '0; base_addr = '0; len = '0;
        in_valid = 1'b0; in_data = '0;
        #12;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ready", in_ready_b, 0);
        chk("rst_addr", wr_addr_a, 0);
        chk("rst_data", wr_data_b, 0);
        check_idle_port("rst");
        @(negedge clk);
        rst = 1'b0;

        run_burst(1, 0, 15, 0, 1'b0);
        run_burst(3, 5, 5, 0, 1'b0);
        run_burst(2, 9, 4, 1, 1'b0);
        run_burst(4, 0, 0, 0, 1'b0);
        run_burst(0, 3, 6, 0, 1'b0);
        run_burst(5, 1, 10, 0, 1'b1);
        run_burst(2, 63, 20, 2, 1'b0);

        // Abandon a burst with an asynchronous reset after three beats
        @(negedge clk);
        start = 1'b1; base_bank = 4'd2; base_addr = 6'd4; len = 10'd8;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 16'hBEEF;
        repeat (3) @(negedge clk);
        chk("pre_rst_en", wr_en_a, 1);
        #2 rst = 1'b1;
        #1;
        check_idle_port("async_rst");
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_ready", in_ready_b, 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_done_after_rst", done_a, 0);
            check_idle_port("after_rst");
        end
        run_burst(9, 2, 5, 0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            run_burst(int'($urandom % 16), int'($urandom % 64), int'($urandom % 41),
                      2, 1'($urandom % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
